// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit_if
// Description : Control and fetch bus between the pipeline and the PC fetch
//               unit. Carries the optional FETCH_STATS_EN counter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_unit_if #(
  parameter int PC_WIDTH = 12,
  parameter int IMEM_AW  = 10
);
  logic                stall;
  logic                redirect;
  logic [PC_WIDTH-1:0] npc;
  logic                halt_req;
  logic                go;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_4;
  logic [IMEM_AW-1:0]  imem_addr;
  logic                if_valid;
  logic                flush_ifid;
  logic                halted;
  logic                misalign_err;
`ifdef FETCH_STATS_EN
  logic [31:0]         fetch_cnt;
  logic [15:0]         redirect_cnt;
`endif

  // Pipeline / hazard side: drives controls, observes fetch state.
  modport master (
    output stall, redirect, npc, halt_req, go,
    input  pc, pc_4, imem_addr, if_valid, flush_ifid, halted, misalign_err
`ifdef FETCH_STATS_EN
    , input fetch_cnt, redirect_cnt
`endif
  );

  // Fetch unit side.
  modport slave (
    input  stall, redirect, npc, halt_req, go,
    output pc, pc_4, imem_addr, if_valid, flush_ifid, halted, misalign_err
`ifdef FETCH_STATS_EN
    , output fetch_cnt, redirect_cnt
`endif
  );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Architectural PC register with run/stall/redirect/halt
//               sequencing for a 5-stage pipeline. Optional fetch statistics
//               counters are enabled by defining FETCH_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
  parameter int                  PC_WIDTH = 12,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 12'h000,
  parameter int                  IMEM_AW  = 10
) (
  input  wire logic        clk,
  input  wire logic        rst,
  pc_fetch_unit_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_flush;
  logic                r_misalign;
  logic [PC_WIDTH-1:0] w_pc_4;
  logic                w_if_valid;

  assign w_pc_4     = r_pc + PC_WIDTH'(4);
  assign w_if_valid = (r_state == ST_RUN) & ~bus.stall & ~r_flush;

  // PC update, run/halt FSM, flush pulse and sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_flush    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      // One-cycle bubble request following every accepted redirect.
      r_flush <= bus.redirect;

      if (bus.redirect) begin
        r_pc <= {bus.npc[PC_WIDTH-1:2], 2'b00};
        if (bus.npc[1:0] != 2'b00) begin
          r_misalign <= 1'b1;
        end
      end else if ((r_state == ST_RUN) && !bus.stall) begin
        r_pc <= w_pc_4;
      end

      // halt_req wins in RUN, go wins in HALT when both are asserted.
      case (r_state)
        ST_RUN:  if (bus.halt_req) r_state <= ST_HALT;
        ST_HALT: if (bus.go)       r_state <= ST_RUN;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign bus.pc           = r_pc;
  assign bus.pc_4         = w_pc_4;
  assign bus.imem_addr    = r_pc[PC_WIDTH-1:2];
  assign bus.if_valid     = w_if_valid;
  assign bus.flush_ifid   = r_flush;
  assign bus.halted       = (r_state == ST_HALT);
  assign bus.misalign_err = r_misalign;

`ifdef FETCH_STATS_EN
  logic [31:0] r_fetch_cnt;
  logic [15:0] r_redirect_cnt;

  // Valid-fetch counter (wrapping) and redirect counter (saturating).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt    <= 32'd0;
      r_redirect_cnt <= 16'd0;
    end else begin
      if (w_if_valid) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (bus.redirect && (r_redirect_cnt != 16'hFFFF)) begin
        r_redirect_cnt <= r_redirect_cnt + 16'd1;
      end
    end
  end

  assign bus.fetch_cnt    = r_fetch_cnt;
  assign bus.redirect_cnt = r_redirect_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed scoreboard bench for pc_fetch_unit. The stimulus
//               process pushes the hand-computed outputs expected during each
//               cycle; a monitor pops and compares them on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pc_fetch_unit_if #(.PC_WIDTH(12), .IMEM_AW(10)) bus ();

  pc_fetch_unit #(
    .PC_WIDTH (12),
    .RESET_PC (12'h000),
    .IMEM_AW  (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [11:0] pc;
    logic [11:0] pc_4;
    logic [9:0]  imem_addr;
    logic        if_valid;
    logic        flush;
    logic        halted;
    logic        mis;
    logic [31:0] fcnt;
    logic [15:0] rcnt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic done   = 1'b0;

  // Expected counter model, advanced from the directed table itself.
  logic [31:0] m_fcnt = 32'd0;
  logic [15:0] m_rcnt = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and push the outputs expected in that cycle.
  task automatic step(input logic r, input logic s, input logic rd, input logic [11:0] n,
                      input logic h, input logic g,
                      input logic [11:0] e_pc, input logic e_v, input logic e_f,
                      input logic e_h, input logic e_m);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    bus.stall    = s;
    bus.redirect = rd;
    bus.npc      = n;
    bus.halt_req = h;
    bus.go       = g;
    e.pc        = e_pc;
    e.pc_4      = e_pc + 12'h004;
    e.imem_addr = e_pc[11:2];
    e.if_valid  = e_v;
    e.flush     = e_f;
    e.halted    = e_h;
    e.mis       = e_m;
    e.fcnt      = m_fcnt;
    e.rcnt      = m_rcnt;
    q.push_back(e);
    if (r) begin
      m_fcnt = 32'd0;
      m_rcnt = 16'd0;
    end else begin
      if (e_v) m_fcnt = m_fcnt + 32'd1;
      if (rd && m_rcnt != 16'hFFFF) m_rcnt = m_rcnt + 16'd1;
    end
  endtask

  // Monitor: compare every presented cycle against the scoreboard head.
  always @(negedge clk) begin
    if (!done && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc",           32'(bus.pc),           32'(e.pc));
      chk("pc_4",         32'(bus.pc_4),         32'(e.pc_4));
      chk("imem_addr",    32'(bus.imem_addr),    32'(e.imem_addr));
      chk("if_valid",     32'(bus.if_valid),     32'(e.if_valid));
      chk("flush_ifid",   32'(bus.flush_ifid),   32'(e.flush));
      chk("halted",       32'(bus.halted),       32'(e.halted));
      chk("misalign_err", 32'(bus.misalign_err), 32'(e.mis));
`ifdef FETCH_STATS_EN
      chk("fetch_cnt",    bus.fetch_cnt,          e.fcnt);
      chk("redirect_cnt", 32'(bus.redirect_cnt), 32'(e.rcnt));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.npc = 12'h000;
    bus.halt_req = 1'b0; bus.go = 1'b0;
    //    rst st rd npc     h  g   pc      v  f  h  m
    step(1, 0, 0, 12'h000, 0, 0, 12'h000, 1, 0, 0, 0); // reset state
    // free run
    step(0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 0, 0, 0);
    step(0, 0, 0, 12'h000, 0, 0, 12'h004, 1, 0, 0, 0);
    step(0, 0, 0, 12'h000, 0, 0, 12'h008, 1, 0, 0, 0);
    step(0, 0, 0, 12'h000, 0, 0, 12'h00C, 1, 0, 0, 0);
    // stall two cycles at 010
    step(0, 1, 0, 12'h000, 0, 0, 12'h010, 0, 0, 0, 0);
    step(0, 1, 0, 12'h000, 0, 0, 12'h010, 0, 0, 0, 0);
    step(0, 0, 0, 12'h000, 0, 0, 12'h010, 1, 0, 0, 0);
    step(0, 0, 0, 12'h000, 0, 0, 12'h014, 1, 0, 0, 0);
    // redirect overrides stall
    step(0, 1, 1, 12'h2A0, 0, 0, 12'h018, 0, 0, 0, 0);
    step(0, 0, 0, 12'h000, 0, 0, 12'h2A0, 0, 1, 0, 0);
    step(0, 0, 0, 12'h000, 0, 0, 12'h2A4, 1, 0, 0, 0);
    // misaligned redirect, then sticky across aligned back-to-back redirects
    step(0, 0, 1, 12'h123, 0, 0, 12'h2A8, 1, 0, 0, 0);
    step(0, 0, 0, 12'h000, 0, 0, 12'h120, 0, 1, 0, 1);
    step(0, 0, 1, 12'h200, 0, 0, 12'h124, 1, 0, 0, 1);
    step(0, 0, 1, 12'h040, 0, 0, 12'h200, 0, 1, 0, 1);
    // halt at 040: same-cycle increment still applies
    step(0, 0, 0, 12'h000, 1, 0, 12'h040, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++)
      step(0, 0, 0, 12'h000, 0, 0, 12'h044, 0, 0, 1, 1);
    step(0, 0, 0, 12'h000, 0, 1, 12'h044, 0, 0, 1, 1);
    step(0, 0, 0, 12'h000, 0, 0, 12'h044, 1, 0, 0, 1);
    step(0, 0, 0, 12'h000, 0, 0, 12'h048, 1, 0, 0, 1);
    // halt_req+go together: RUN -> halt wins, HALT -> go wins
    step(0, 0, 0, 12'h000, 1, 0, 12'h04C, 1, 0, 0, 1);
    step(0, 0, 0, 12'h000, 1, 1, 12'h050, 0, 0, 1, 1);
    step(0, 0, 0, 12'h000, 0, 0, 12'h050, 1, 0, 0, 1);
    // redirect accepted while halted, then wrap at FFC
    step(0, 0, 0, 12'h000, 1, 0, 12'h054, 1, 0, 0, 1);
    step(0, 0, 1, 12'hFF8, 0, 0, 12'h058, 0, 0, 1, 1);
    step(0, 0, 0, 12'h000, 0, 0, 12'hFF8, 0, 1, 1, 1);
    step(0, 0, 0, 12'h000, 0, 1, 12'hFF8, 0, 0, 1, 1);
    step(0, 0, 0, 12'h000, 0, 0, 12'hFF8, 1, 0, 0, 1);
    step(0, 0, 0, 12'h000, 0, 0, 12'hFFC, 1, 0, 0, 1);
    step(0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 0, 0, 1);
    // reset with stall+redirect+halt pending: redirect discarded
    step(1, 1, 1, 12'h300, 1, 0, 12'h004, 0, 0, 0, 1);
    step(0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 0, 0, 0);
    // counters: 10 valid fetches then 1 redirect
    for (int i = 1; i < 10; i++)
      step(0, 0, 0, 12'h000, 0, 0, 12'(i * 4), 1, 0, 0, 0);
    step(0, 0, 1, 12'h100, 0, 0, 12'h028, 1, 0, 0, 0);
    step(0, 0, 0, 12'h000, 0, 0, 12'h100, 0, 1, 0, 0);
    step(0, 0, 0, 12'h000, 0, 0, 12'h104, 1, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Consumer end of the next-PC path: holds the architectural PC register and loads the 12-bit next PC produced by the next-PC generator.
- Drives instruction-memory fetch and the IF/ID valid and flush controls.
- Sequences run, stall, redirect and halt/resume for the 5-stage pipeline.
- Also returns pc_4 to the next-PC generator, closing the loop.

Parameters:
- PC_WIDTH, 12, PC width in bits (byte address).
- RESET_PC, 12'h000, PC value loaded on reset.
- IMEM_AW, 10, instruction-memory word address width; equals PC_WIDTH-2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- stall  input  1  hazard unit hold; PC and IF/ID held.
- redirect  input  1  branch taken / jump / jr resolved this cycle; load npc.
- npc  input  PC_WIDTH  next PC from the next-PC generator; sampled only when redirect=1.
- halt_req  input  1  syscall-halt decoded; freeze fetch.
- go  input  1  resume pulse from the halted state.
- pc  output  PC_WIDTH  current PC register.
- pc_4  output  PC_WIDTH  pc+4, combinational, wraps mod 2^PC_WIDTH; sent to the next-PC generator.
- imem_addr  output  IMEM_AW  pc[PC_WIDTH-1:2].
- if_valid  output  1  fetched instruction at pc is valid for IF/ID capture this cycle.
- flush_ifid  output  1  registered one-cycle pulse; IF/ID must insert a bubble.
- halted  output  1  high while in HALT.
- misalign_err  output  1  sticky; set when a redirect npc has npc[1:0]!=0.

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=RUN, flush_ifid=0, misalign_err=0, halted=0. All inputs are ignored that cycle.
- States: RUN and HALT. halted = (state==HALT).
- if_valid = RUN & ~stall & ~flush_ifid. In HALT, if_valid=0.
- Per-cycle PC update priority, highest first:
  - (1) rst.
  - (2) redirect: pc <= {npc[PC_WIDTH-1:2],2'b00}, flush_ifid <= 1. Redirect overrides stall and is accepted in both states.
  - (3) state==HALT: pc held.
  - (4) stall: pc held.
  - (5) otherwise pc <= pc_4.
- flush_ifid <= 0 on any cycle without redirect. Back-to-back redirects give back-to-back flush pulses.
- misalign_err is set on redirect with npc[1:0]!=0. It is cleared only by rst. The PC is forced word-aligned as in rule (2).
- RUN->HALT: on halt_req=1 at the edge. The PC update of that same cycle still applies per the priority rules; HALT then freezes the PC from the next cycle.
- HALT->RUN: on go=1 at the edge. The first fetch is from the held pc in the following cycle.
- halt_req and go asserted together:
  - In RUN, halt_req wins (enter HALT).
  - In HALT, go wins (return to RUN).
- Wrap: pc=12'hFFC with no redirect/stall/halt -> pc=12'h000 next cycle. No error flag.
- Latency: redirect at edge N -> pc=npc visible after edge N. First valid fetch at the new pc is cycle N+2, because flush_ifid occupies cycle N+1.
- rst mid-stall, mid-halt or mid-redirect returns to the full reset state; the redirect is discarded.

Optional Feature:
- Macro FETCH_STATS_EN.
- When defined, adds outputs fetch_cnt[31:0] and redirect_cnt[15:0]. Both are cleared on rst.
  - fetch_cnt increments on each cycle with if_valid=1.
  - redirect_cnt increments on each accepted redirect and saturates at 16'hFFFF.
  - fetch_cnt wraps mod 2^32.
- When undefined, these ports and their counters do not exist. All other behaviour is identical.

Test Plan:
- Reset then 4 free-running cycles -> pc = 000, 004, 008, 00C; if_valid=1 each cycle; flush_ifid=0.
- At pc=010, assert stall for 2 cycles -> pc holds 010 for 2 cycles with if_valid=0, then 014.
- redirect=1, npc=12'h2A0 with stall=1 at the same time -> pc=2A0 next cycle; flush_ifid=1 for exactly one cycle; if_valid=0 that cycle and 1 the cycle after.
- redirect with npc=12'h123 -> pc=120; misalign_err=1 and stays 1 across later redirects until rst.
- At pc=040, assert halt_req -> pc=044, halted=1, pc frozen over 5 cycles. Then go=1 -> halted=0, fetch resumes at 044, next pc 048. Also verify halt_req+go together in HALT resumes.
- From pc=FFC free-run -> pc=000. With FETCH_STATS_EN, after reset + 10 valid fetches + 1 redirect -> fetch_cnt=10, redirect_cnt=1.
